// File: rtl/uart_bus_master_pkg.sv
// uart_bus_master_pkg
// Shared constants and state encodings for the UART-to-bus debug bridge.
// Holds the command/response byte values, datapath widths, the parser
// state enum and the receiver state enum.
package uart_bus_master_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 16;

    localparam logic [BYTE_W-1:0] CMD_READ    = 8'h52;  // 'R'
    localparam logic [BYTE_W-1:0] CMD_WRITE   = 8'h57;  // 'W'
    localparam logic [BYTE_W-1:0] RSP_ACK     = 8'h4B;  // 'K'
    localparam logic [BYTE_W-1:0] RSP_UNKNOWN = 8'h3F;  // '?'
    localparam logic [BYTE_W-1:0] RSP_TIMEOUT = 8'h54;  // 'T'

    typedef enum logic [2:0] {
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_BUS,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_bus_master_phy.sv
// uart_bus_master_phy
// 8N1 byte deserialiser and serialiser, bit period CLK_DIV clk cycles.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   ser_rx / ser_tx      serial line in / out (idle high)
//   rx_data, rx_strobe   received byte, one-cycle strobe at stop-bit sample
//   rx_ferr              one-cycle pulse when the stop bit samples 0
//   tx_data, tx_start    byte to send; start honoured when tx_busy is low
//   tx_busy              transmitter occupied; drops in the last stop-bit
//                        cycle so a following byte can start back-to-back
module uart_bus_master_phy
    import uart_bus_master_pkg::*;
#(
    parameter int unsigned CLK_DIV = 651
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ser_rx,
    output logic              ser_tx,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_strobe,
    output logic              rx_ferr,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_start,
    output logic              tx_busy
);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);

    rx_state_t         r_rx_state;
    logic [CNT_W-1:0]  r_rx_cnt;
    logic [2:0]        r_rx_bit;
    logic [BYTE_W-1:0] r_rx_shift;
    logic [BYTE_W-1:0] r_rx_data;
    logic              r_rx_strobe;
    logic              r_rx_ferr;

    logic [BYTE_W:0]   r_tx_shift;
    logic [3:0]        r_tx_bits;
    logic [CNT_W-1:0]  r_tx_cnt;
    logic              r_tx_active;
    logic              r_tx_busy;
    logic              r_ser_tx;

    assign rx_data   = r_rx_data;
    assign rx_strobe = r_rx_strobe;
    assign rx_ferr   = r_rx_ferr;
    assign ser_tx    = r_ser_tx;
    assign tx_busy   = r_tx_busy;

    // Receiver: half-bit to the start midpoint, then full bits
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rx_state  <= RX_IDLE;
            r_rx_cnt    <= '0;
            r_rx_bit    <= '0;
            r_rx_shift  <= '0;
            r_rx_data   <= '0;
            r_rx_strobe <= 1'b0;
            r_rx_ferr   <= 1'b0;
        end else begin
            r_rx_strobe <= 1'b0;
            r_rx_ferr   <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (!ser_rx) begin
                        r_rx_state <= RX_START;
                        r_rx_cnt   <= HALF_LAST;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt != '0) begin
                        r_rx_cnt <= r_rx_cnt - CNT_W'(1);
                    end else if (ser_rx) begin
                        // Line back high at the midpoint: glitch, not a start bit
                        r_rx_state <= RX_IDLE;
                    end else begin
                        r_rx_state <= RX_DATA;
                        r_rx_cnt   <= BIT_LAST;
                        r_rx_bit   <= '0;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt != '0) begin
                        r_rx_cnt <= r_rx_cnt - CNT_W'(1);
                    end else begin
                        r_rx_shift <= {ser_rx, r_rx_shift[BYTE_W-1:1]};
                        r_rx_cnt   <= BIT_LAST;
                        if (r_rx_bit == 3'd7) begin
                            r_rx_state <= RX_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 3'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt != '0) begin
                        r_rx_cnt <= r_rx_cnt - CNT_W'(1);
                    end else begin
                        // Back to idle at the stop midpoint so the next start edge is seen
                        r_rx_state <= RX_IDLE;
                        if (ser_rx) begin
                            r_rx_data   <= r_rx_shift;
                            r_rx_strobe <= 1'b1;
                        end else begin
                            r_rx_ferr <= 1'b1;
                        end
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // Transmitter: start bit, 8 data bits, stop bit; reloadable in last stop cycle
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tx_shift  <= '0;
            r_tx_bits   <= '0;
            r_tx_cnt    <= '0;
            r_tx_active <= 1'b0;
            r_tx_busy   <= 1'b0;
            r_ser_tx    <= 1'b1;
        end else if (tx_start) begin
            r_ser_tx    <= 1'b0;
            r_tx_shift  <= {1'b1, tx_data};
            r_tx_bits   <= 4'd9;
            r_tx_cnt    <= BIT_LAST;
            r_tx_active <= 1'b1;
            r_tx_busy   <= 1'b1;
        end else if (r_tx_active) begin
            if (r_tx_cnt != '0) begin
                r_tx_cnt <= r_tx_cnt - CNT_W'(1);
                if (r_tx_bits == 4'd0 && r_tx_cnt == CNT_W'(1)) begin
                    r_tx_busy <= 1'b0;
                end
            end else if (r_tx_bits != 4'd0) begin
                r_ser_tx   <= r_tx_shift[0];
                r_tx_shift <= {1'b1, r_tx_shift[BYTE_W:1]};
                r_tx_bits  <= r_tx_bits - 4'd1;
                r_tx_cnt   <= BIT_LAST;
            end else begin
                r_tx_active <= 1'b0;
                r_ser_tx    <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_bus_master.sv
// uart_bus_master
// Serial-to-bus debug bridge: parses 'R'/'W' commands from the UART line,
// runs one PicoRV32 native-interface transfer and replies over UART.
// Optional feature macro: UART_BUS_MASTER_TIMEOUT_EN adds a bus wait limit
// of TIMEOUT_CYCLES cycles, after which the reply is 'T'.
// Ports:
//   clk, resetn                      clock, synchronous active-low reset
//   ser_rx / ser_tx                  UART line in / out
//   mem_valid, mem_addr, mem_wdata,  bus request (word address, wstrb F
//   mem_wstrb                        for writes, 0 for reads)
//   mem_rdata, mem_ready             bus completion and read data
//   busy                             command accepted until reply done
module uart_bus_master
    import uart_bus_master_pkg::*;
#(
    parameter int unsigned CLK_DIV        = 651,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ser_rx,
    output logic              ser_tx,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    state_t            r_state;
    logic [1:0]        r_byte_cnt;
    logic              r_is_write;
    logic [DATA_W-1:0] r_shift;
    logic              r_mem_valid;
    logic [DATA_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [3:0]        r_mem_wstrb;
    logic [DATA_W-1:0] r_resp_buf;
    logic [2:0]        r_resp_left;
    logic              r_busy;

    logic [BYTE_W-1:0] w_rx_data;
    logic              w_rx_strobe;
    logic              w_rx_ferr;
    logic              w_tx_start;
    logic              w_tx_busy;
    logic [DATA_W-1:0] w_shift_next;

`ifdef UART_BUS_MASTER_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LIMIT =
        (TIMEOUT_CYCLES == 0)     ? '0 :
        (TIMEOUT_CYCLES > 65536)  ? '1 : CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] r_to_cnt;
`else
    // Without the timeout S_BUS holds until mem_ready; the parameter is inert.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_inert
    end
`endif

    assign mem_valid = r_mem_valid;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign busy      = r_busy;

    // Little-endian fields: each new byte enters at the top
    assign w_shift_next = {w_rx_data, r_shift[DATA_W-1:BYTE_W]};

    // Feed the next reply byte as soon as the serialiser can take it
    assign w_tx_start = (r_state == S_RESP) && (r_resp_left != 3'd0) && !w_tx_busy;

    uart_bus_master_phy #(
        .CLK_DIV (CLK_DIV)
    ) u_phy (
        .clk       (clk),
        .resetn    (resetn),
        .ser_rx    (ser_rx),
        .ser_tx    (ser_tx),
        .rx_data   (w_rx_data),
        .rx_strobe (w_rx_strobe),
        .rx_ferr   (w_rx_ferr),
        .tx_data   (r_resp_buf[BYTE_W-1:0]),
        .tx_start  (w_tx_start),
        .tx_busy   (w_tx_busy)
    );

    // Command parser, bus handshake and response sequencer
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= S_CMD;
            r_byte_cnt  <= '0;
            r_is_write  <= 1'b0;
            r_shift     <= '0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_resp_buf  <= '0;
            r_resp_left <= '0;
            r_busy      <= 1'b0;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
            r_to_cnt    <= '0;
`endif
        end else begin
            case (r_state)
                S_CMD: begin
                    if (w_rx_strobe) begin
                        r_busy     <= 1'b1;
                        r_byte_cnt <= '0;
                        if (w_rx_data == CMD_READ || w_rx_data == CMD_WRITE) begin
                            r_is_write <= (w_rx_data == CMD_WRITE);
                            r_state    <= S_ADDR;
                        end else begin
                            r_resp_buf  <= DATA_W'(RSP_UNKNOWN);
                            r_resp_left <= 3'd1;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_ADDR: begin
                    if (w_rx_ferr) begin
                        r_state <= S_CMD;
                        r_busy  <= 1'b0;
                    end else if (w_rx_strobe) begin
                        r_shift    <= w_shift_next;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_mem_addr <= {w_shift_next[DATA_W-1:2], 2'b00};
                            r_byte_cnt <= '0;
                            if (r_is_write) begin
                                r_state <= S_WDATA;
                            end else begin
                                r_mem_wstrb <= 4'h0;
                                r_mem_valid <= 1'b1;
                                r_state     <= S_BUS;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
                                r_to_cnt    <= '0;
`endif
                            end
                        end
                    end
                end
                S_WDATA: begin
                    if (w_rx_ferr) begin
                        r_state <= S_CMD;
                        r_busy  <= 1'b0;
                    end else if (w_rx_strobe) begin
                        r_shift    <= w_shift_next;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_mem_wdata <= w_shift_next;
                            r_mem_wstrb <= 4'hF;
                            r_mem_valid <= 1'b1;
                            r_state     <= S_BUS;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
                            r_to_cnt    <= '0;
`endif
                        end
                    end
                end
                S_BUS: begin
                    if (mem_ready) begin
                        r_mem_valid <= 1'b0;
                        r_state     <= S_RESP;
                        if (r_is_write) begin
                            r_resp_buf  <= DATA_W'(RSP_ACK);
                            r_resp_left <= 3'd1;
                        end else begin
                            r_resp_buf  <= mem_rdata;
                            r_resp_left <= 3'd4;
                        end
                    end
`ifdef UART_BUS_MASTER_TIMEOUT_EN
                    else if (r_to_cnt >= TO_LIMIT) begin
                        r_mem_valid <= 1'b0;
                        r_resp_buf  <= DATA_W'(RSP_TIMEOUT);
                        r_resp_left <= 3'd1;
                        r_state     <= S_RESP;
                    end else begin
                        r_to_cnt <= r_to_cnt + CNT_W'(1);
                    end
`endif
                end
                S_RESP: begin
                    if (w_tx_start) begin
                        r_resp_buf  <= r_resp_buf >> BYTE_W;
                        r_resp_left <= r_resp_left - 3'd1;
                    end else if (r_resp_left == 3'd0 && !w_tx_busy) begin
                        // Last byte handed over and its stop bit is ending
                        r_state <= S_CMD;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_CMD;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// tb_uart_bus_master
// Directed bench for uart_bus_master with CLK_DIV=16, TIMEOUT_CYCLES=64.
// Background processes model the bus target and decode the TX line.
module tb_uart_bus_master;

    localparam int BIT = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ser_rx = 1'b1;
    logic        ser_tx;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // bus target model state
    bit          ready_en = 1'b1;
    int          bus_wait = 3;
    logic [31:0] bus_rdata = '0;
    int          pulses = 0;
    int          fall_cyc = 0;
    logic [31:0] cap_addr = '0;
    logic [31:0] cap_wdata = '0;
    logic [3:0]  cap_wstrb = '0;

    // TX decoder output
    logic [7:0] rx_q[$];
    int         start_q[$];
    int         stop_errs = 0;

    uart_bus_master #(
        .CLK_DIV        (16),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .ser_rx    (ser_rx),
        .ser_tx    (ser_tx),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bus target: completes after bus_wait cycles, records the request
    initial begin
        int  wait_left;
        bit  prev_valid;
        wait_left  = 0;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (mem_valid && !prev_valid) pulses++;
            if (!mem_valid && prev_valid) fall_cyc = cyc;
            prev_valid = mem_valid;
            if (!mem_valid) begin
                wait_left = bus_wait;
            end else if (ready_en) begin
                if (wait_left == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = bus_rdata;
                    cap_addr  = mem_addr;
                    cap_wdata = mem_wdata;
                    cap_wstrb = mem_wstrb;
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // TX decoder: samples mid-bit, records each byte and its start cycle
    initial begin
        logic [7:0] b;
        int         sc;
        forever begin
            @(negedge clk);
            if (resetn && ser_tx == 1'b0) begin
                sc = cyc;
                repeat (BIT / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    b[i] = ser_tx;
                end
                repeat (BIT) @(negedge clk);
                if (ser_tx !== 1'b1) stop_errs++;
                rx_q.push_back(b);
                start_q.push_back(sc);
            end
        end
    end

    task automatic uart_send(input logic [7:0] b, input logic stop_bit, input int stop_len);
        @(negedge clk);
        ser_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ser_rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        ser_rx = stop_bit;
        repeat (stop_len) @(negedge clk);
        ser_rx = 1'b1;
    endtask

    task automatic send_bytes(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4);
        uart_send(b0, 1'b1, BIT);
        uart_send(b1, 1'b1, BIT);
        uart_send(b2, 1'b1, BIT);
        uart_send(b3, 1'b1, BIT);
        uart_send(b4, 1'b1, BIT);
    endtask

    task automatic wait_bytes(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 32'(rx_q.size()), 32'(n));
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        if (rx_q.size() > 0) got = rx_q.pop_front();
        else got = ~exp;
        check_eq(tag, 32'(got), 32'(exp));
    endtask

    task automatic flush_rx();
        rx_q.delete();
        start_q.delete();
    endtask

    initial begin
        int p0;
        int n;

        // reset state
        repeat (5) @(negedge clk);
        check_eq("rst_ser_tx", 32'(ser_tx), 32'd1);
        check_eq("rst_mem_valid", 32'(mem_valid), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_mem_wdata", mem_wdata, 32'h0);
        check_eq("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        // read: 52 00 10 00 00 -> DEADBEEF after 3 wait cycles
        flush_rx();
        bus_wait  = 3;
        bus_rdata = 32'hDEADBEEF;
        p0 = pulses;
        uart_send(8'h52, 1'b1, BIT);
        check_eq("rd_busy_after_cmd", 32'(busy), 32'd1);
        uart_send(8'h00, 1'b1, BIT);
        uart_send(8'h10, 1'b1, BIT);
        uart_send(8'h00, 1'b1, BIT);
        uart_send(8'h00, 1'b1, BIT);
        wait_bytes("rd_count", 4, 3000);
        check_eq("rd_busy_in_stop", 32'(busy), 32'd1);
        check_eq("rd_addr", cap_addr, 32'h00001000);
        check_eq("rd_wstrb", 32'(cap_wstrb), 32'h0);
        check_eq("rd_pulses", 32'(pulses - p0), 32'd1);
        if (start_q.size() == 4) begin
            check_eq("rd_first_start", 32'(start_q[0] - fall_cyc), 32'd1);
            check_eq("rd_gap01", 32'(start_q[1] - start_q[0]), 32'd160);
            check_eq("rd_gap23", 32'(start_q[3] - start_q[2]), 32'd160);
        end else begin
            check_eq("rd_start_count", 32'(start_q.size()), 32'd4);
        end
        expect_byte("rd_b0", 8'hEF);
        expect_byte("rd_b1", 8'hBE);
        expect_byte("rd_b2", 8'hAD);
        expect_byte("rd_b3", 8'hDE);
        repeat (12) @(negedge clk);
        check_eq("rd_busy_done", 32'(busy), 32'd0);

        // write: 57 07 20 00 00 78 56 34 12
        flush_rx();
        p0 = pulses;
        send_bytes(8'h57, 8'h07, 8'h20, 8'h00, 8'h00);
        uart_send(8'h78, 1'b1, BIT);
        uart_send(8'h56, 1'b1, BIT);
        uart_send(8'h34, 1'b1, BIT);
        uart_send(8'h12, 1'b1, BIT);
        wait_bytes("wr_count", 1, 1000);
        expect_byte("wr_ack", 8'h4B);
        check_eq("wr_addr", cap_addr, 32'h00002004);
        check_eq("wr_wdata", cap_wdata, 32'h12345678);
        check_eq("wr_wstrb", 32'(cap_wstrb), 32'hF);
        check_eq("wr_pulses", 32'(pulses - p0), 32'd1);
        repeat (20) @(negedge clk);

        // bad command, then a read
        flush_rx();
        p0 = pulses;
        uart_send(8'hA5, 1'b1, BIT);
        wait_bytes("bad_count", 1, 1000);
        expect_byte("bad_reply", 8'h3F);
        check_eq("bad_pulses", 32'(pulses - p0), 32'd0);
        repeat (20) @(negedge clk);
        bus_rdata = 32'h01234567;
        send_bytes(8'h52, 8'h44, 8'h33, 8'h22, 8'h11);
        wait_bytes("bad_rd_count", 4, 3000);
        check_eq("bad_rd_addr", cap_addr, 32'h11223344);
        expect_byte("bad_rd_b0", 8'h67);
        expect_byte("bad_rd_b1", 8'h45);
        expect_byte("bad_rd_b2", 8'h23);
        expect_byte("bad_rd_b3", 8'h01);
        repeat (20) @(negedge clk);

        // framing error on the second address byte
        flush_rx();
        p0 = pulses;
        uart_send(8'h52, 1'b1, BIT);
        uart_send(8'h00, 1'b1, BIT);
        uart_send(8'h10, 1'b0, 12);
        repeat (400) @(negedge clk);
        check_eq("ferr_no_reply", 32'(rx_q.size()), 32'd0);
        check_eq("ferr_pulses", 32'(pulses - p0), 32'd0);
        check_eq("ferr_busy", 32'(busy), 32'd0);
        bus_rdata = 32'hCAFEF00D;
        send_bytes(8'h52, 8'h08, 8'h00, 8'h00, 8'h00);
        wait_bytes("ferr_rd_count", 4, 3000);
        check_eq("ferr_rd_addr", cap_addr, 32'h00000008);
        expect_byte("ferr_rd_b0", 8'h0D);
        expect_byte("ferr_rd_b1", 8'hF0);
        expect_byte("ferr_rd_b2", 8'hFE);
        expect_byte("ferr_rd_b3", 8'hCA);
        repeat (20) @(negedge clk);

        // bus never ready
        flush_rx();
        ready_en = 1'b0;
        send_bytes(8'h52, 8'h00, 8'h30, 8'h00, 8'h00);
        n = 0;
        while (!mem_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq("to_valid_rise", 32'(mem_valid), 32'd1);
`ifdef UART_BUS_MASTER_TIMEOUT_EN
        n = 0;
        while (mem_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("to_valid_cycles", 32'(n), 32'd64);
        wait_bytes("to_count", 1, 1000);
        expect_byte("to_reply", 8'h54);
        ready_en = 1'b1;
`else
        n = 0;
        while (mem_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("noto_valid_cycles", 32'(n), 32'd1000);
        check_eq("noto_no_reply", 32'(rx_q.size()), 32'd0);
        bus_rdata = 32'h0BADF00D;
        ready_en = 1'b1;
        wait_bytes("noto_rd_count", 4, 2000);
        expect_byte("noto_rd_b0", 8'h0D);
`endif
        repeat (20) @(negedge clk);

        // reset during the second response byte
        flush_rx();
        bus_rdata = 32'hA1B2C3D4;
        send_bytes(8'h52, 8'h00, 8'h00, 8'h00, 8'h00);
        wait_bytes("rst_first_byte", 1, 3000);
        expect_byte("rst_b0", 8'hD4);
        repeat (40) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_ser_tx", 32'(ser_tx), 32'd1);
        check_eq("rst_mid_busy", 32'(busy), 32'd0);
        check_eq("rst_mid_valid", 32'(mem_valid), 32'd0);
        resetn = 1'b1;
        repeat (300) @(negedge clk);
        flush_rx();
        bus_rdata = 32'h55AA1234;
        send_bytes(8'h52, 8'h40, 8'h00, 8'h00, 8'h00);
        wait_bytes("post_rst_count", 4, 3000);
        check_eq("post_rst_addr", cap_addr, 32'h00000040);
        expect_byte("post_rst_b0", 8'h34);
        expect_byte("post_rst_b1", 8'h12);
        expect_byte("post_rst_b2", 8'hAA);
        expect_byte("post_rst_b3", 8'h55);
        repeat (20) @(negedge clk);
        check_eq("stop_bits", 32'(stop_errs), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
